conv_stream_engine: RTL

//  Parametrised streaming 1-D convolution engine, successor to the fixed-filter conv_* blocks. Filter is streamed per vector
//  (no ROM); P parallel MAC lanes; optional ReLU. Accepts LENX x-samples and LENF f-taps on valid/ready inputs and emits

---
 rtl/conv_stream_engine.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_stream_engine.sv
// Streaming 1-D convolution engine: loads an x vector and a filter over valid/ready,
// computes y[k] = sum_j x[k+j]*f[j] on P saturating MAC lanes and drains y in order.
module conv_stream_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LENX  = 64,
    parameter int unsigned LENF  = 33,
    parameter int unsigned P     = 8,
    parameter bit          RELU  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    input  logic [WIDTH-1:0] s_data_in_f,
    input  logic             s_valid_f,
    output logic             s_ready_f,
    output logic [WIDTH-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);
    localparam int unsigned SIZE = LENX - LENF + 1;
    localparam int unsigned XAW  = (LENX > 1) ? $clog2(LENX) : 1;
    localparam int unsigned FAW  = (LENF > 1) ? $clog2(LENF) : 1;
    localparam int unsigned YAW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned XCW  = $clog2(LENX + 1);
    localparam int unsigned FCW  = $clog2(LENF + 1);
    localparam int unsigned YCW  = $clog2(SIZE + 1);
    localparam int unsigned BW   = $clog2(SIZE + P + 1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {ST_LOAD, ST_COMPUTE} state_t;

    function automatic logic [WIDTH-1:0] sat_mul(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] pa;
        logic signed [2*WIDTH-1:0] pb;
        logic signed [2*WIDTH-1:0] p;
        pa = a;
        pb = b;
        p  = pa * pb;
        if (p[2*WIDTH-1:WIDTH-1] == '0 || p[2*WIDTH-1:WIDTH-1] == '1)
            return p[WIDTH-1:0];
        return p[2*WIDTH-1] ? SMIN : SMAX;
    endfunction

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? SMIN : SMAX;
        return s[WIDTH-1:0];
    endfunction

    state_t           r_state;
    logic [XCW-1:0]   r_x_cnt;
    logic [FCW-1:0]   r_f_cnt;
    logic             r_ready_x;
    logic             r_ready_f;
    logic             r_iss_active;
    logic [BW-1:0]    r_iss_base;
    logic [FAW-1:0]   r_j;
    logic             r_rd_valid;
    logic             r_rd_first;
    logic             r_rd_last;
    logic [BW-1:0]    r_rd_base;
    logic             r_mac_last;
    logic [BW-1:0]    r_mac_base;
    logic [YCW-1:0]   r_wr_cnt;
    logic [YCW-1:0]   r_rd_ptr;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;

    logic [WIDTH-1:0] r_x_mem [LENX];
    logic [WIDTH-1:0] r_f_mem [LENF];
    logic [WIDTH-1:0] r_y_mem [SIZE];
    logic [WIDTH-1:0] r_xd    [P];
    logic [WIDTH-1:0] r_fd;
    logic [WIDTH-1:0] r_acc   [P];

    logic             w_x_fire;
    logic             w_f_fire;
    logic             w_y_fire;
    logic             w_drain_done;
    logic [XCW-1:0]   w_x_cnt_nxt;
    logic [FCW-1:0]   w_f_cnt_nxt;
    logic             w_last_grp_iss;
    logic             w_last_grp_mac;
    logic [YCW-1:0]   w_live;
    logic [XAW-1:0]   w_xaddr [P];
    logic [WIDTH-1:0] w_sum   [P];
    logic [WIDTH-1:0] w_res   [P];

    assign s_ready_x    = r_ready_x;
    assign s_ready_f    = r_ready_f;
    assign m_valid_y    = r_m_valid;
    assign m_data_out_y = r_m_data;

    assign w_x_fire       = s_valid_x && r_ready_x;
    assign w_f_fire       = s_valid_f && r_ready_f;
    assign w_y_fire       = r_m_valid && m_ready_y;
    assign w_drain_done   = w_y_fire && (r_rd_ptr == YCW'(SIZE));
    assign w_x_cnt_nxt    = r_x_cnt + XCW'(w_x_fire);
    assign w_f_cnt_nxt    = r_f_cnt + FCW'(w_f_fire);
    assign w_last_grp_iss = (32'(r_iss_base) + P >= SIZE);
    assign w_last_grp_mac = (32'(r_mac_base) + P >= SIZE);
    assign w_live         = w_last_grp_mac ? YCW'(SIZE - 32'(r_mac_base)) : YCW'(P);

    // Lanes past the end of y in the last group read a harmless clamped address.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_xaddr[i] = XAW'(LENX - 1);
            if (32'(r_iss_base) + 32'(i) < SIZE)
                w_xaddr[i] = XAW'(32'(r_iss_base) + 32'(i) + 32'(r_j));
        end
    end

    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_sum[i] = r_rd_first ? sat_mul(r_xd[i], r_fd)
                                  : sat_add(r_acc[i], sat_mul(r_xd[i], r_fd));
            w_res[i] = (RELU && r_acc[i][WIDTH-1]) ? '0 : r_acc[i];
        end
    end

    // Storage and datapath registers that need no reset.
    always_ff @(posedge clk) begin
        if (w_x_fire)
            r_x_mem[XAW'(r_x_cnt)] <= s_data_in_x;
        if (w_f_fire)
            r_f_mem[FAW'(r_f_cnt)] <= s_data_in_f;
        if (r_iss_active) begin
            for (int i = 0; i < P; i++)
                r_xd[i] <= r_x_mem[w_xaddr[i]];
            r_fd <= r_f_mem[r_j];
        end
        if (r_rd_valid) begin
            for (int i = 0; i < P; i++)
                r_acc[i] <= w_sum[i];
        end
        if (r_mac_last) begin
            for (int i = 0; i < P; i++)
                if (32'(r_mac_base) + 32'(i) < SIZE)
                    r_y_mem[YAW'(32'(r_mac_base) + 32'(i))] <= w_res[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_LOAD;
            r_x_cnt      <= '0;
            r_f_cnt      <= '0;
            r_ready_x    <= 1'b0;
            r_ready_f    <= 1'b0;
            r_iss_active <= 1'b0;
            r_iss_base   <= '0;
            r_j          <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_first   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_base    <= '0;
            r_mac_last   <= 1'b0;
            r_mac_base   <= '0;
            r_wr_cnt     <= '0;
        end else begin
            r_rd_valid <= r_iss_active;
            r_rd_first <= (r_j == '0);
            r_rd_last  <= (r_j == FAW'(LENF - 1));
            r_rd_base  <= r_iss_base;
            r_mac_last <= r_rd_valid && r_rd_last;
            r_mac_base <= r_rd_base;

            if (w_drain_done)
                r_wr_cnt <= '0;
            else if (r_mac_last)
                r_wr_cnt <= r_wr_cnt + w_live;

            // One tap per cycle; groups issue back-to-back.
            if (r_iss_active) begin
                if (r_j == FAW'(LENF - 1)) begin
                    r_j        <= '0;
                    r_iss_base <= r_iss_base + BW'(P);
                    if (w_last_grp_iss)
                        r_iss_active <= 1'b0;
                end else begin
                    r_j <= r_j + FAW'(1);
                end
            end

            case (r_state)
                ST_LOAD: begin
                    if (r_x_cnt == XCW'(LENX) && r_f_cnt == FCW'(LENF) && r_wr_cnt == '0) begin
                        r_state      <= ST_COMPUTE;
                        r_iss_active <= 1'b1;
                        r_iss_base   <= '0;
                        r_j          <= '0;
                        r_ready_x    <= 1'b0;
                        r_ready_f    <= 1'b0;
                    end else begin
                        r_x_cnt   <= w_x_cnt_nxt;
                        r_f_cnt   <= w_f_cnt_nxt;
                        r_ready_x <= (w_x_cnt_nxt < XCW'(LENX));
                        r_ready_f <= (w_f_cnt_nxt < FCW'(LENF));
                    end
                end
                ST_COMPUTE: begin
                    // Reopen loading as soon as the last group lands; drain overlaps the next load.
                    if (r_mac_last && w_last_grp_mac) begin
                        r_state   <= ST_LOAD;
                        r_x_cnt   <= '0;
                        r_f_cnt   <= '0;
                        r_ready_x <= 1'b1;
                        r_ready_f <= 1'b1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Output register with prefetch from the y buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_drain_done) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
        end else if ((!r_m_valid || m_ready_y) && (r_rd_ptr < r_wr_cnt)) begin
            r_m_data  <= r_y_mem[YAW'(r_rd_ptr)];
            r_m_valid <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + YCW'(1);
        end else if (w_y_fire) begin
            r_m_valid <= 1'b0;
        end
    end

endmodule
